// File: rtl/stack_game_core.sv
// Block-stacking game engine: control FSM plus datapath that slides the block,
// evaluates drops against the block below and tracks score, chances and level.
module stack_game_core #(
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned X_W          = 8,
  parameter int unsigned Y_W          = 7,
  parameter int unsigned ROWS         = 15,
  parameter int unsigned ROW_H        = 8,
  parameter int unsigned BLOCK_W_INIT = 32,
  parameter int unsigned CHANCES      = 3,
  parameter int unsigned TICK_DIV     = 833333,
  parameter int unsigned SPEED_STEP   = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           KEY,
  output logic           sync,
  output logic           o,
  output logic [X_W-1:0] x,
  output logic [X_W-1:0] width,
  output logic [X_W-1:0] prev_x,
  output logic [X_W-1:0] prev_width,
  output logic [Y_W-1:0] y,
  output logic [3:0]     score,
  output logic [3:0]     chances,
  output logic [2:0]     level,
  output logic [1:0]     game_status
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned ROW_W  = $clog2(ROWS + 1);
  localparam int unsigned SPD_W  = $clog2(SPEED_STEP + 1);
  localparam int unsigned P_W    = X_W + 1;

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [X_W-1:0]    BLOCK_W_RST = X_W'(BLOCK_W_INIT);
  localparam logic [X_W-1:0]    PREV_X_RST  = X_W'((SCREEN_W - BLOCK_W_INIT) / 2);
  localparam logic [Y_W-1:0]    Y_RST       = Y_W'(ROW_H * (ROWS - 1));
  localparam logic [3:0]        CHANCES_RST = 4'(CHANCES);
  localparam logic [P_W-1:0]    SCREEN_P    = P_W'(SCREEN_W);
  localparam logic [ROW_W-1:0]  ROWS_R      = ROW_W'(ROWS);
  localparam logic [SPD_W-1:0]  SPD_LAST    = SPD_W'(SPEED_STEP - 1);
  localparam logic              DIR_RIGHT   = 1'b0;
  localparam logic              DIR_LEFT    = 1'b1;

  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_EVAL, S_WIN, S_LOSE} state_t;

  state_t            state_q, state_n;
  logic [TICK_W-1:0] tick_cnt;
  logic              key_m, key_s, key_d, press;
  logic              dir_q, dir_n;
  logic [ROW_W-1:0]  row_q, row_n;
  logic [SPD_W-1:0]  spd_q, spd_n;
  logic [X_W-1:0]    x_n, width_n, prev_x_n, prev_width_n;
  logic [Y_W-1:0]    y_n;
  logic [3:0]        score_n, chances_n;
  logic [2:0]        level_n;
  logic              o_n;
  logic [P_W-1:0]    step, x_p, w_p, px_p, pw_p, x_end, p_end, lo, hi, ov_w;
  logic              hit;

  function automatic logic [Y_W-1:0] row_to_y(input logic [ROW_W-1:0] r);
    return Y_W'(ROW_H * (ROWS - 1 - 32'(r)));
  endfunction

  function automatic logic [1:0] status_of(input state_t s);
    case (s)
      S_IDLE:         return 2'd0;
      S_MOVE, S_EVAL: return 2'd1;
      S_WIN:          return 2'd2;
      default:        return 2'd3;
    endcase
  endfunction

  // Free-running movement tick; sync marks the wrap cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
      sync     <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      sync     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
      sync     <= 1'b0;
    end
  end

  // Synchroniser flops reset low so a key held through reset is not a press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_m <= 1'b0;
      key_s <= 1'b0;
      key_d <= 1'b0;
      press <= 1'b0;
    end else begin
      key_m <= KEY;
      key_s <= key_m;
      key_d <= key_s;
      press <= key_d & ~key_s;
    end
  end

  // Overlap of the moving block with the block below, at X_W+1 bits.
  always_comb begin
    step  = P_W'(level) + P_W'(1);
    x_p   = P_W'(x);
    w_p   = P_W'(width);
    px_p  = P_W'(prev_x);
    pw_p  = P_W'(prev_width);
    x_end = x_p + w_p;
    p_end = px_p + pw_p;
    lo    = (x_p > px_p) ? x_p : px_p;
    hi    = (x_end < p_end) ? x_end : p_end;
    hit   = hi > lo;
    ov_w  = hi - lo;
  end

  always_comb begin
    state_n      = state_q;
    x_n          = x;
    dir_n        = dir_q;
    width_n      = width;
    prev_x_n     = prev_x;
    prev_width_n = prev_width;
    row_n        = row_q;
    spd_n        = spd_q;
    score_n      = score;
    chances_n    = chances;
    level_n      = level;
    o_n          = o;
    y_n          = y;
    case (state_q)
      S_IDLE: begin
        if (press) state_n = S_MOVE;
      end
      S_MOVE: begin
        if (press) begin
          state_n = S_EVAL;
        end else if (sync) begin
          if (dir_q == DIR_RIGHT) begin
            if (x_end + step > SCREEN_P) begin
              x_n   = X_W'(SCREEN_P - w_p);
              dir_n = DIR_LEFT;
            end else begin
              x_n = X_W'(x_p + step);
            end
          end else begin
            if (x_p < step) begin
              x_n   = '0;
              dir_n = DIR_RIGHT;
            end else begin
              x_n = X_W'(x_p - step);
            end
          end
        end
      end
      S_EVAL: begin
        x_n   = '0;
        dir_n = DIR_RIGHT;
        if (hit) begin
          o_n          = 1'b1;
          prev_x_n     = X_W'(lo);
          prev_width_n = X_W'(ov_w);
          width_n      = X_W'(ov_w);
          if (score != 4'hF) score_n = score + 4'd1;
          row_n = row_q + ROW_W'(1);
          if (spd_q == SPD_LAST) begin
            spd_n = '0;
            if (level != 3'd7) level_n = level + 3'd1;
          end else begin
            spd_n = spd_q + SPD_W'(1);
          end
          // y keeps its last playing value once the tower is complete
          if (row_n == ROWS_R) begin
            state_n = S_WIN;
          end else begin
            state_n = S_MOVE;
            y_n     = row_to_y(row_n);
          end
        end else begin
          o_n = 1'b0;
          if (chances <= 4'd1) begin
            chances_n = '0;
            state_n   = S_LOSE;
          end else begin
            chances_n = chances - 4'd1;
            state_n   = S_MOVE;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (press) begin
          state_n      = S_IDLE;
          x_n          = '0;
          dir_n        = DIR_RIGHT;
          width_n      = BLOCK_W_RST;
          prev_x_n     = PREV_X_RST;
          prev_width_n = BLOCK_W_RST;
          row_n        = '0;
          spd_n        = '0;
          score_n      = '0;
          chances_n    = CHANCES_RST;
          level_n      = '0;
          o_n          = 1'b0;
          y_n          = Y_RST;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      game_status <= 2'd0;
      x           <= '0;
      dir_q       <= DIR_RIGHT;
      width       <= BLOCK_W_RST;
      prev_x      <= PREV_X_RST;
      prev_width  <= BLOCK_W_RST;
      row_q       <= '0;
      spd_q       <= '0;
      score       <= '0;
      chances     <= CHANCES_RST;
      level       <= '0;
      o           <= 1'b0;
      y           <= Y_RST;
    end else begin
      state_q     <= state_n;
      game_status <= status_of(state_n);
      x           <= x_n;
      dir_q       <= dir_n;
      width       <= width_n;
      prev_x      <= prev_x_n;
      prev_width  <= prev_width_n;
      row_q       <= row_n;
      spd_q       <= spd_n;
      score       <= score_n;
      chances     <= chances_n;
      level       <= level_n;
      o           <= o_n;
      y           <= y_n;
    end
  end

endmodule
